// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: multicycle FETCH/DECODE/EXEC/WRITEBACK sequencer holding NZCV and checking Cond in DECODE.
// Optional macro ARM_MC_EOR_EN adds EOR (Funct[4:1]=0001) to the data-processing decode.
module arm_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0]        instr,
    input  logic [3:0]         alu_flags,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_ctrl,
    output logic [1:0]         imm_src,
    output logic [1:0]         reg_src,
    output logic               reg_write,
    output logic [3:0]         flags_o,
    output logic [STATE_W-1:0] state_o
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB  = 4'd4,
        MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       reg_write;
    } ctrl_t;

    localparam ctrl_t FETCH_CTRL = '{pc_write: 1'b1, adr_src: 1'b0, mem_write: 1'b0, ir_write: 1'b1,
                                     result_src: 2'b10, alu_src_a: 1'b1, alu_src_b: 2'b10,
                                     alu_ctrl: 3'b000, reg_write: 1'b0};

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [3:0] flags_q, flags_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic       rd_pc;
    logic       unused_rn;
    assign cond      = instr[19:16];
    assign op        = instr[15:14];
    assign funct     = instr[13:8];
    assign rd_pc     = (instr[3:0] == 4'hF);
    assign unused_rn = ^instr[7:4];

    // Data-processing decode; dp_logic marks ops whose S bit leaves C and V alone.
    logic [2:0] dp_ctrl;
    logic       dp_ok, dp_logic;
    always_comb begin
        dp_ctrl  = 3'b000;
        dp_ok    = 1'b1;
        dp_logic = 1'b0;
        case (funct[4:1])
            4'b0100: dp_ctrl = 3'b000;
            4'b0010: dp_ctrl = 3'b001;
            4'b0000: begin dp_ctrl = 3'b010; dp_logic = 1'b1; end
            4'b1100: begin dp_ctrl = 3'b011; dp_logic = 1'b1; end
`ifdef ARM_MC_EOR_EN
            4'b0001: begin dp_ctrl = 3'b100; dp_logic = 1'b1; end
`endif
            default: dp_ok = 1'b0;
        endcase
    end

    logic n_f, z_f, c_f, v_f, cond_pass;
    assign {n_f, z_f, c_f, v_f} = flags_q;
    always_comb begin
        case (cond)
            4'h0: cond_pass = z_f;
            4'h1: cond_pass = !z_f;
            4'h2: cond_pass = c_f;
            4'h3: cond_pass = !c_f;
            4'h4: cond_pass = n_f;
            4'h5: cond_pass = !n_f;
            4'h6: cond_pass = v_f;
            4'h7: cond_pass = !v_f;
            4'h8: cond_pass = c_f && !z_f;
            4'h9: cond_pass = !c_f || z_f;
            4'hA: cond_pass = (n_f == v_f);
            4'hB: cond_pass = (n_f != v_f);
            4'hC: cond_pass = !z_f && (n_f == v_f);
            4'hD: cond_pass = z_f || (n_f != v_f);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        flags_d = flags_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (!cond_pass)      state_d = FETCH;
                else if (op == 2'b01) state_d = MEMADR;
                else if (op == 2'b10) state_d = BRANCH;
                else if (op == 2'b00) state_d = funct[5] ? EXECI : EXECR;
                else                  state_d = FETCH;
            end
            MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXECR, EXECI: begin
                state_d = dp_ok ? ALUWB : FETCH;
                if (dp_ok && funct[0]) begin
                    flags_d[3:2] = alu_flags[3:2];
                    if (!dp_logic) flags_d[1:0] = alu_flags[1:0];
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Outputs are computed for the state being entered so they are registered alongside it.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            FETCH:  ctrl_d = FETCH_CTRL;
            DECODE: begin ctrl_d.alu_src_a = 1'b1; ctrl_d.alu_src_b = 2'b10; ctrl_d.result_src = 2'b10; end
            MEMADR: ctrl_d.alu_src_b = 2'b01;
            MEMRD:  ctrl_d.adr_src = 1'b1;
            MEMWB:  begin ctrl_d.result_src = 2'b01; ctrl_d.reg_write = 1'b1; ctrl_d.pc_write = rd_pc; end
            MEMWR:  begin ctrl_d.adr_src = 1'b1; ctrl_d.mem_write = 1'b1; end
            EXECR:  ctrl_d.alu_ctrl = dp_ctrl;
            EXECI:  begin ctrl_d.alu_src_b = 2'b01; ctrl_d.alu_ctrl = dp_ctrl; end
            ALUWB:  begin ctrl_d.reg_write = 1'b1; ctrl_d.pc_write = rd_pc; end
            BRANCH: begin ctrl_d.alu_src_b = 2'b01; ctrl_d.result_src = 2'b10; ctrl_d.pc_write = 1'b1; end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= FETCH_CTRL;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            flags_q <= flags_d;
        end
    end

    // Enables are forced low combinationally so they drop in the same cycle reset rises.
    assign pc_write   = ctrl_q.pc_write  & ~reset;
    assign mem_write  = ctrl_q.mem_write & ~reset;
    assign ir_write   = ctrl_q.ir_write  & ~reset;
    assign reg_write  = ctrl_q.reg_write & ~reset;
    assign adr_src    = ctrl_q.adr_src;
    assign result_src = ctrl_q.result_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_ctrl   = ctrl_q.alu_ctrl;
    assign imm_src    = op;
    assign reg_src    = {(op == 2'b01) && !funct[0], op == 2'b10};
    assign flags_o    = flags_q;
    assign state_o    = STATE_W'(state_q);
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb_arm_multicycle_ctrl: directed and random instruction streams against an instruction-level reference model.
module tb_arm_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] instr;
    logic [3:0]  alu_flags;
    logic        pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write;
    logic [1:0]  result_src, alu_src_b, imm_src, reg_src;
    logic [2:0]  alu_ctrl;
    logic [3:0]  flags_o, state_o;

    arm_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .imm_src(imm_src), .reg_src(reg_src), .reg_write(reg_write), .flags_o(flags_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [3:0] m_flags;
    bit         force_fl;
    logic [3:0] force_val;
    int         path_q[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALU op code for a data-processing command, -1 when the command is not supported.
    function automatic int alu_code(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 0;
            4'b0010: return 1;
            4'b0000: return 2;
            4'b1100: return 3;
`ifdef ARM_MC_EOR_EN
            4'b0001: return 4;
`endif
            default: return -1;
        endcase
    endfunction

    task automatic run_instr(input logic [19:0] ins, input string nm);
        logic [1:0] op;
        logic [5:0] fn;
        bit         rd15;
        int         code, st;
        op   = ins[15:14];
        fn   = ins[13:8];
        rd15 = (ins[3:0] == 4'hF);
        code = alu_code(fn[4:1]);
        path_q.delete();
        path_q.push_back(0);
        path_q.push_back(1);
        if (cond_ok(ins[19:16], m_flags)) begin
            case (op)
                2'b01: begin
                    path_q.push_back(2);
                    if (fn[0]) begin path_q.push_back(3); path_q.push_back(4); end
                    else path_q.push_back(5);
                end
                2'b10: path_q.push_back(9);
                2'b00: begin
                    path_q.push_back(fn[5] ? 7 : 6);
                    if (code >= 0) path_q.push_back(8);
                end
                default: ;
            endcase
        end
        instr = ins;
        foreach (path_q[k]) begin
            st = path_q[k];
            #1;
            chk({nm, ":state"}, 8'(state_o), 8'(st));
            chk({nm, ":pc_write"}, 8'(pc_write), 8'(st == 0 || st == 9 || ((st == 4 || st == 8) && rd15)));
            chk({nm, ":ir_write"}, 8'(ir_write), 8'(st == 0));
            chk({nm, ":mem_write"}, 8'(mem_write), 8'(st == 5));
            chk({nm, ":reg_write"}, 8'(reg_write), 8'(st == 4 || st == 8));
            chk({nm, ":alu_ctrl"}, 8'(alu_ctrl), ((st == 6 || st == 7) && code >= 0) ? 8'(code) : 8'd0);
            chk({nm, ":imm_src"}, 8'(imm_src), 8'(op));
            if (st == 0 || st == 1) begin
                chk({nm, ":src_a"}, 8'(alu_src_a), 8'd1);
                chk({nm, ":src_b"}, 8'(alu_src_b), 8'd2);
                chk({nm, ":result_src"}, 8'(result_src), 8'd2);
            end
            if (st == 0) chk({nm, ":adr_src"}, 8'(adr_src), 8'd0);
            if (st == 2 || st == 7 || st == 9) chk({nm, ":src_b"}, 8'(alu_src_b), 8'd1);
            if (st == 6) chk({nm, ":src_b"}, 8'(alu_src_b), 8'd0);
            if (st == 3 || st == 5) chk({nm, ":adr_src"}, 8'(adr_src), 8'd1);
            if (st == 4) chk({nm, ":result_src"}, 8'(result_src), 8'd1);
            if (st == 8) chk({nm, ":result_src"}, 8'(result_src), 8'd0);
            if (st == 5) chk({nm, ":reg_src1"}, 8'(reg_src[1]), 8'd1);
            if (st == 9) chk({nm, ":reg_src0"}, 8'(reg_src[0]), 8'd1);
            alu_flags = force_fl ? force_val : 4'($urandom_range(0, 15));
            if ((st == 6 || st == 7) && code >= 0 && fn[0]) begin
                m_flags[3:2] = alu_flags[3:2];
                if (code <= 1) m_flags[1:0] = alu_flags[1:0];
            end
            @(negedge clk);
        end
        #1;
        chk({nm, ":flags"}, 8'(flags_o), 8'(m_flags));
        chk({nm, ":back_to_fetch"}, 8'(state_o), 8'd0);
        #1;
    endtask

    initial begin
        logic [19:0] r;
        reset     = 1'b1;
        instr     = 20'h0;
        alu_flags = 4'h0;
        force_fl  = 1'b0;
        force_val = 4'h0;
        m_flags   = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst:state", 8'(state_o), 8'd0);
        chk("rst:pc_write", 8'(pc_write), 8'd0);
        chk("rst:ir_write", 8'(ir_write), 8'd0);
        chk("rst:mem_write", 8'(mem_write), 8'd0);
        chk("rst:reg_write", 8'(reg_write), 8'd0);
        chk("rst:flags", 8'(flags_o), 8'd0);
        reset = 1'b0;

        run_instr(20'hE2811, "add_imm");
        run_instr(20'hE5912, "ldr");
        run_instr(20'hE5812, "str");
        force_fl  = 1'b1;
        force_val = 4'b0110;
        run_instr(20'hE0511, "subs");
        force_fl  = 1'b0;
        run_instr(20'h0A000, "beq_taken");

        // Reset in the middle of an LDR while flags are non-zero.
        instr = 20'hE5912;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midrst:pre_state", 8'(state_o), 8'd2);
        reset = 1'b1;
        #1;
        chk("midrst:state", 8'(state_o), 8'd0);
        chk("midrst:pc_write", 8'(pc_write), 8'd0);
        chk("midrst:ir_write", 8'(ir_write), 8'd0);
        chk("midrst:flags", 8'(flags_o), 8'd0);
        m_flags = 4'h0;
        @(negedge clk);
        reset = 1'b0;

        run_instr(20'h0A000, "beq_not_taken");
        run_instr(20'hE2211, "eor_imm");
        run_instr(20'hE591F, "ldr_pc");
        run_instr(20'hE281F, "add_pc");
        run_instr(20'hF2811, "cond_nv");
        run_instr(20'hEC000, "op11");

        for (int i = 0; i < 300; i++) begin
            r = 20'($urandom);
            if ($urandom_range(0, 1) == 1) r[19:16] = 4'hE;
            run_instr(r, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
